// File: rtl/crank_cam_gen.sv
// crank_cam_gen
//   Synthetic crankshaft/camshaft signal generator. Produces a toothed-wheel
//   crank waveform (TEETH slots per revolution, the last MISSING slots held
//   low) and a cam window that is high over a slot range of every other
//   revolution. The tooth period in clock cycles is programmable at run time.
//
// Ports
//   clk        in  1          rising-edge clock
//   rst        in  1          asynchronous, active-low reset
//   ena        in  1          run enable (level)
//   period_we  in  1          write strobe for period
//   period     in  PER_WIDTH  clocks per tooth slot (values below 4 stop the generator)
//   cap        out 1          crank waveform
//   cam        out 1          cam waveform
//   slot       out 6          current slot index 0..TEETH-1
//   rev        out 1          revolution parity
//   sync       out 1          pulse in the first cycle of slot 0, revolution 0
module crank_cam_gen #(
  parameter int PER_WIDTH = 24,
  parameter int TEETH     = 60,
  parameter int MISSING   = 2,
  parameter int CAM_RISE  = 10,
  parameter int CAM_FALL  = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 period_we,
  input  logic [PER_WIDTH-1:0] period,
  output logic                 cap,
  output logic                 cam,
  output logic [5:0]           slot,
  output logic                 rev,
  output logic                 sync
);

  localparam logic [5:0]           LAST_SLOT  = 6'(TEETH - 1);
  localparam logic [5:0]           REAL_SLOTS = 6'(TEETH - MISSING);
  localparam logic [5:0]           CAM_ON     = 6'(CAM_RISE);
  localparam logic [5:0]           CAM_OFF    = 6'(CAM_FALL);
  localparam logic [PER_WIDTH-1:0] MIN_PER    = PER_WIDTH'(4);
  localparam logic [PER_WIDTH-1:0] ONE        = PER_WIDTH'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t               state_q, state_d;
  logic [PER_WIDTH-1:0] per_shadow_q, per_shadow_d;
  logic [PER_WIDTH-1:0] per_act_q, per_act_d;
  logic [PER_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [5:0]           slot_q, slot_d;
  logic                 rev_q, rev_d;
  logic                 cap_q, cap_d;
  logic                 cam_q, cam_d;
  logic                 sync_q, sync_d;
  logic                 run_d;

  // Next-state logic. Every path that leaves RUN (enable low, or a too-short
  // shadow period met at a slot boundary) falls through to the cleared
  // defaults, so the generator always restarts from slot 0 of revolution 0.
  // The shadow value sampled here is the registered one, so a write landing
  // on a slot boundary only affects the slot after that.
  always_comb begin
    per_shadow_d = period_we ? period : per_shadow_q;
    state_d      = IDLE;
    per_act_d    = '0;
    pcnt_d       = '0;
    slot_d       = '0;
    rev_d        = 1'b0;

    if (state_q == IDLE) begin
      if (ena && (per_shadow_q >= MIN_PER)) begin
        state_d   = RUN;
        per_act_d = per_shadow_q;
      end
    end else if (ena) begin
      if (pcnt_q == per_act_q - ONE) begin
        if (per_shadow_q >= MIN_PER) begin
          state_d   = RUN;
          per_act_d = per_shadow_q;
          if (slot_q == LAST_SLOT) begin
            rev_d = ~rev_q;
          end else begin
            slot_d = slot_q + 6'd1;
            rev_d  = rev_q;
          end
        end
      end else begin
        state_d   = RUN;
        per_act_d = per_act_q;
        pcnt_d    = pcnt_q + ONE;
        slot_d    = slot_q;
        rev_d     = rev_q;
      end
    end
  end

  // Outputs are derived from the next counter values so that the registered
  // outputs line up with the counters they describe. The high phase is the
  // truncated half period, which leaves the odd cycle in the low phase.
  always_comb begin
    run_d  = (state_d == RUN);
    cap_d  = run_d && (slot_d < REAL_SLOTS) && (pcnt_d < (per_act_d >> 1));
    cam_d  = run_d && !rev_d && (slot_d >= CAM_ON) && (slot_d < CAM_OFF);
    sync_d = run_d && !rev_d && (slot_d == 6'd0) && (pcnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      per_shadow_q <= '0;
      per_act_q    <= '0;
      pcnt_q       <= '0;
      slot_q       <= '0;
      rev_q        <= 1'b0;
      cap_q        <= 1'b0;
      cam_q        <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_shadow_q <= per_shadow_d;
      per_act_q    <= per_act_d;
      pcnt_q       <= pcnt_d;
      slot_q       <= slot_d;
      rev_q        <= rev_d;
      cap_q        <= cap_d;
      cam_q        <= cam_d;
      sync_q       <= sync_d;
    end
  end

  assign cap  = cap_q;
  assign cam  = cam_q;
  assign slot = slot_q;
  assign rev  = rev_q;
  assign sync = sync_q;

endmodule

// File: tb/tb_crank_cam_gen.sv
// tb_crank_cam_gen
//   Self-checking bench for crank_cam_gen. A behavioural model tracks the
//   generator as an absolute slot count plus an offset inside the current
//   slot; slot, revolution and waveform values are derived from those with
//   plain arithmetic. Scenario tasks also measure waveform timing directly.
module tb_crank_cam_gen;

  localparam int PER_WIDTH = 24;
  localparam int TEETH     = 60;
  localparam int MISSING   = 2;
  localparam int CAM_RISE  = 10;
  localparam int CAM_FALL  = 40;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 ena = 1'b0;
  logic                 period_we = 1'b0;
  logic [PER_WIDTH-1:0] period = '0;
  logic                 cap, cam, rev, sync;
  logic [5:0]           slot;

  int n_tests = 0;
  int n_fail  = 0;

  crank_cam_gen #(
    .PER_WIDTH(PER_WIDTH),
    .TEETH    (TEETH),
    .MISSING  (MISSING),
    .CAM_RISE (CAM_RISE),
    .CAM_FALL (CAM_FALL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .period_we(period_we),
    .period   (period),
    .cap      (cap),
    .cam      (cam),
    .slot     (slot),
    .rev      (rev),
    .sync     (sync)
  );

  always #5 clk = ~clk;

  // Reference model: m_abs counts slots since start modulo two revolutions,
  // m_pos is the cycle offset inside the current slot of length m_len.
  bit m_run;
  int m_shadow, m_len, m_abs, m_pos, m_old;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_shadow = 0; m_len = 0; m_abs = 0; m_pos = 0;
    end else begin
      m_old = m_shadow;
      if (period_we) m_shadow = int'(period);
      if (!m_run) begin
        if (ena && m_old >= 4) begin
          m_run = 1; m_len = m_old; m_abs = 0; m_pos = 0;
        end
      end else if (!ena) begin
        m_run = 0; m_len = 0; m_abs = 0; m_pos = 0;
      end else if (m_pos + 1 == m_len) begin
        if (m_old < 4) begin
          m_run = 0; m_len = 0; m_abs = 0; m_pos = 0;
        end else begin
          m_pos = 0; m_len = m_old; m_abs = (m_abs + 1) % (2 * TEETH);
        end
      end else begin
        m_pos = m_pos + 1;
      end
    end
  end

  function automatic logic [9:0] exp_vec();
    int s, r;
    logic c, cm, sy;
    s  = m_abs % TEETH;
    r  = (m_abs / TEETH) % 2;
    c  = m_run && (s < TEETH - MISSING) && (m_pos < m_len / 2);
    cm = m_run && (r == 0) && (s >= CAM_RISE) && (s < CAM_FALL);
    sy = m_run && (m_abs == 0) && (m_pos == 0);
    return {c, cm, 6'(s), r[0], sy};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {cap, cam, slot, rev, sync};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic go_idle();
    ena = 1'b0; period_we = 1'b1; period = '0;
    step();
    period_we = 1'b0;
    step();
  endtask

  task automatic write_period(input int p);
    period_we = 1'b1; period = PER_WIDTH'(p);
    step();
    period_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) begin
      n_tests++;
      if (dut_vec() !== 10'b0)
        $display("[TB] FAIL reset_hold got=%b exp=%b", dut_vec(), 10'b0);
      if (dut_vec() !== 10'b0) n_fail++;
      step();
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("[TB] FAIL reset_release got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_tooth_waveform(input int per);
    int hi, lo, rev_len, gap, hi_run, lo_run, rises, cam_cnt, first_cam, cam_r1;
    logic prev_cap;
    int sync_t[$];
    hi = per / 2; lo = per - hi; rev_len = TEETH * per; gap = lo + MISSING * per;
    go_idle();
    ena = 1'b1;
    write_period(per);
    n_tests++;
    if (dut_vec() !== 10'b0) begin
      n_fail++;
      $display("[TB] FAIL start_latency per=%0d got=%b exp=%b", per, dut_vec(), 10'b0);
    end
    step();
    prev_cap = 1'b0; hi_run = 0; lo_run = 0; rises = 0;
    cam_cnt = 0; first_cam = -1; cam_r1 = 0;
    for (int t = 0; t <= 2 * rev_len + 1; t++) begin
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL wave_model per=%0d t=%0d got=%b exp=%b", per, t, dut_vec(), exp_vec());
      end
      if (cap) begin
        if (!prev_cap) begin
          if (t < rev_len) rises++;
          if (t > 0) begin
            n_tests++;
            if (lo_run != ((t % rev_len == 0) ? gap : lo)) begin
              n_fail++;
              $display("[TB] FAIL low_time per=%0d t=%0d got=%0d exp=%0d", per, t, lo_run,
                       (t % rev_len == 0) ? gap : lo);
            end
          end
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_cap) begin
          n_tests++;
          if (hi_run != hi) begin
            n_fail++;
            $display("[TB] FAIL high_time per=%0d t=%0d got=%0d exp=%0d", per, t, hi_run, hi);
          end
          lo_run = 0;
        end
        lo_run++;
      end
      if (sync) sync_t.push_back(t);
      if (cam) begin
        if (t < rev_len) begin
          cam_cnt++;
          if (first_cam < 0) first_cam = t;
        end else if (t < 2 * rev_len) begin
          cam_r1++;
        end
      end
      prev_cap = cap;
      step();
    end
    n_tests++;
    if (rises != TEETH - MISSING) begin
      n_fail++;
      $display("[TB] FAIL rising_edges per=%0d got=%0d exp=%0d", per, rises, TEETH - MISSING);
    end
    n_tests++;
    if (cam_cnt != (CAM_FALL - CAM_RISE) * per || first_cam != CAM_RISE * per) begin
      n_fail++;
      $display("[TB] FAIL cam_window per=%0d got=%0d@%0d exp=%0d@%0d", per, cam_cnt, first_cam,
               (CAM_FALL - CAM_RISE) * per, CAM_RISE * per);
    end
    n_tests++;
    if (cam_r1 != 0) begin
      n_fail++;
      $display("[TB] FAIL cam_rev1 per=%0d got=%0d exp=0", per, cam_r1);
    end
    n_tests++;
    if (sync_t.size() != 2 || sync_t[0] != 0 || sync_t[sync_t.size()-1] != 2 * rev_len) begin
      n_fail++;
      $display("[TB] FAIL sync_spacing per=%0d got=%0d pulses last=%0d exp=2 last=%0d", per,
               sync_t.size(), sync_t[sync_t.size()-1], 2 * rev_len);
    end
  endtask

  // Write new period at write_t; measure start cycles of slots a and a+1.
  task automatic test_period_change(input string name, input int write_t, input int new_per,
                                    input int sl, input int exp_a, input int exp_b, input int exp_hi);
    int start_a, start_b, hi_a;
    go_idle();
    ena = 1'b1;
    write_period(8);
    step();
    start_a = -1; start_b = -1; hi_a = 0;
    for (int t = 0; t < 100; t++) begin
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL %s_model t=%0d got=%b exp=%b", name, t, dut_vec(), exp_vec());
      end
      if (slot == 6'(sl) && start_a < 0) start_a = t;
      if (slot == 6'(sl + 1) && start_b < 0) start_b = t;
      if (slot == 6'(sl) && cap) hi_a++;
      period_we = (t == write_t);
      period = PER_WIDTH'(new_per);
      step();
    end
    n_tests++;
    if (start_a != exp_a || start_b != exp_b || hi_a != exp_hi) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0d/%0d/%0d exp=%0d/%0d/%0d", name, start_a, start_b, hi_a,
               exp_a, exp_b, exp_hi);
    end
  endtask

  task automatic test_short_period();
    go_idle();
    ena = 1'b1;
    write_period(3);
    for (int t = 0; t < 20; t++) begin
      n_tests++;
      if (dut_vec() !== 10'b0) begin
        n_fail++;
        $display("[TB] FAIL short_idle t=%0d got=%b exp=%b", t, dut_vec(), 10'b0);
      end
      step();
    end
    write_period(8);
    step();
    for (int t = 0; t < 40; t++) begin
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL short_run_model t=%0d got=%b exp=%b", t, dut_vec(), exp_vec());
      end
      if (t == 23 || t == 24) begin
        n_tests++;
        if ((t == 23 && slot !== 6'd2) || (t == 24 && dut_vec() !== 10'b0)) begin
          n_fail++;
          $display("[TB] FAIL short_run_stop t=%0d got=%b slot=%0d", t, dut_vec(), slot);
        end
      end
      period_we = (t == 20);
      period = PER_WIDTH'(3);
      step();
    end
  endtask

  task automatic test_ena_drop();
    int r;
    r = $urandom_range(0, 7);
    go_idle();
    ena = 1'b1;
    write_period(8);
    step();
    for (int t = 0; t < 240 + r; t++) begin
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL ena_model t=%0d got=%b exp=%b", t, dut_vec(), exp_vec());
      end
      step();
    end
    n_tests++;
    if (slot !== 6'd30) begin
      n_fail++;
      $display("[TB] FAIL ena_slot got=%0d exp=30", slot);
    end
    ena = 1'b0;
    step();
    n_tests++;
    if (dut_vec() !== 10'b0) begin
      n_fail++;
      $display("[TB] FAIL ena_drop got=%b exp=%b", dut_vec(), 10'b0);
    end
    ena = 1'b1;
    step();
    n_tests++;
    if (dut_vec() !== 10'b1_0_000000_0_1) begin
      n_fail++;
      $display("[TB] FAIL ena_restart got=%b exp=%b", dut_vec(), 10'b1_0_000000_0_1);
    end
    step();
    n_tests++;
    if (sync !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("[TB] FAIL ena_sync_width got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    int n;
    go_idle();
    ena = 1'b1;
    write_period($urandom_range(4, 12));
    n = $urandom_range(100, 600);
    repeat (n) begin
      step();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL async_model got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (dut_vec() !== 10'b0) begin
      n_fail++;
      $display("[TB] FAIL async_clear got=%b exp=%b", dut_vec(), 10'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 30; t++) begin
      step();
      n_tests++;
      if (dut_vec() !== 10'b0) begin
        n_fail++;
        $display("[TB] FAIL async_stay_idle t=%0d got=%b exp=%b", t, dut_vec(), 10'b0);
      end
    end
  endtask

  task automatic test_random();
    go_idle();
    ena = 1'b1;
    write_period(6);
    for (int t = 0; t < 4000; t++) begin
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL random t=%0d got=%b exp=%b", t, dut_vec(), exp_vec());
      end
      period_we = ($urandom_range(0, 39) == 0);
      period = PER_WIDTH'($urandom_range(2, 14));
      if ($urandom_range(0, 149) == 0) ena = ~ena;
      step();
    end
    ena = 1'b0;
    period_we = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_tooth_waveform(8);
    test_tooth_waveform(9);
    test_period_change("period_change", 43, 16, 6, 48, 64, 8);
    test_period_change("back_to_back", 7, 12, 2, 16, 28, 6);
    test_short_period();
    test_ena_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
